// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter of two writeback sources onto the regfile write port, with a busy scoreboard.
// Latency: one registered write stage (commit two edges after accept); ready is combinational and a loser holds until granted.
module regfile_wb_arbiter #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [REGBITS-1:0]    req0_wa,
    input  logic [WIDTH-1:0]      req0_wd,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [REGBITS-1:0]    req1_wa,
    input  logic [WIDTH-1:0]      req1_wd,
    output logic                  req1_ready,
    input  logic                  rsv_valid,
    input  logic [REGBITS-1:0]    rsv_wa,
    input  logic [REGBITS-1:0]    chk_ra1,
    input  logic [REGBITS-1:0]    chk_ra2,
    output logic                  chk_busy1,
    output logic                  chk_busy2,
    output logic [2**REGBITS-1:0] busy_vec,
    output logic                  rsv_err,
    output logic                  rf_regwrite,
    output logic [REGBITS-1:0]    rf_wa,
    output logic [WIDTH-1:0]      rf_wd
);
    localparam int N = 2**REGBITS;

    logic               prio;
    logic               src;
    logic [N-1:0]       busy;
    logic [N-1:0]       busy_next;
    logic               acc0;
    logic               acc1;
    logic               contested;
    logic               rsv_set;
    logic               clr;
    logic               err_hit;
    logic [REGBITS-1:0] sel_wa;
    logic [WIDTH-1:0]   sel_wd;

    assign req0_ready = !req1_valid || !prio;
    assign req1_ready = !req0_valid ||  prio;
    assign acc0       = req0_valid && req0_ready;
    assign acc1       = req1_valid && req1_ready;
    assign contested  = req0_valid && req1_valid;
    assign sel_wa     = acc1 ? req1_wa : req0_wa;
    assign sel_wd     = acc1 ? req1_wd : req0_wd;

    // Clear happens on the regfile commit edge, only for multicycle-unit writes.
    assign clr     = rf_regwrite && src;
    assign rsv_set = rsv_valid && (rsv_wa != '0);
    // A reservation landing on the same edge its register is released is not a double reservation.
    assign err_hit = rsv_set && busy[rsv_wa] && !(clr && (rf_wa == rsv_wa));

    always_comb begin
        busy_next = busy;
        if (clr)
            busy_next[rf_wa] = 1'b0;
        if (rsv_set)
            busy_next[rsv_wa] = 1'b1;
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio        <= 1'b0;
            src         <= 1'b0;
            busy        <= '0;
            rsv_err     <= 1'b0;
            rf_regwrite <= 1'b0;
            rf_wa       <= '0;
            rf_wd       <= '0;
        end else begin
            if (contested)
                prio <= !prio;
            if (acc0 || acc1) begin
                rf_regwrite <= (sel_wa != '0);
                rf_wa       <= sel_wa;
                rf_wd       <= sel_wd;
                src         <= acc1;
            end else begin
                rf_regwrite <= 1'b0;
            end
            busy <= busy_next;
            if (err_hit)
                rsv_err <= 1'b1;
        end
    end

    assign busy_vec  = busy;
    assign chk_busy1 = busy[chk_ra1];
    assign chk_busy2 = busy[chk_ra2];

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: arbitration order, write stage, scoreboard and reset.
module tb_regfile_wb_arbiter;
    logic        clk;
    logic        reset;
    logic        req0_valid;
    logic [4:0]  req0_wa;
    logic [31:0] req0_wd;
    logic        req0_ready;
    logic        req1_valid;
    logic [4:0]  req1_wa;
    logic [31:0] req1_wd;
    logic        req1_ready;
    logic        rsv_valid;
    logic [4:0]  rsv_wa;
    logic [4:0]  chk_ra1;
    logic [4:0]  chk_ra2;
    logic        chk_busy1;
    logic        chk_busy2;
    logic [31:0] busy_vec;
    logic        rsv_err;
    logic        rf_regwrite;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int n_checks;
    int n_fail;

    regfile_wb_arbiter #(.WIDTH(32), .REGBITS(5)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_wa(req0_wa), .req0_wd(req0_wd), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_wa(req1_wa), .req1_wd(req1_wd), .req1_ready(req1_ready),
        .rsv_valid(rsv_valid), .rsv_wa(rsv_wa),
        .chk_ra1(chk_ra1), .chk_ra2(chk_ra2), .chk_busy1(chk_busy1), .chk_busy2(chk_busy2),
        .busy_vec(busy_vec), .rsv_err(rsv_err),
        .rf_regwrite(rf_regwrite), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [4:0]  a_wa [3];
    logic [31:0] a_wd [3];
    logic [4:0]  b_wa [2];
    logic [31:0] b_wd [2];

    initial begin
        int i0;
        int i1;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        req0_valid = 1'b0; req0_wa = '0; req0_wd = '0;
        req1_valid = 1'b0; req1_wa = '0; req1_wd = '0;
        rsv_valid = 1'b0; rsv_wa = '0; chk_ra1 = '0; chk_ra2 = '0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_regwrite", 32'(rf_regwrite), 0);
        check("rst_wa", 32'(rf_wa), 0);
        check("rst_wd", rf_wd, 0);
        check("rst_busy", busy_vec, 0);
        check("rst_err", 32'(rsv_err), 0);

        // Single uncontested pipeline write
        req0_valid = 1'b1; req0_wa = 5'd5; req0_wd = 32'hDEADBEEF;
        #1;
        check("w1_ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        check("w1_regwrite", 32'(rf_regwrite), 1);
        check("w1_wa", 32'(rf_wa), 5);
        check("w1_wd", rf_wd, 32'hDEADBEEF);
        tick();
        check("w1_idle_regwrite", 32'(rf_regwrite), 0);
        check("w1_idle_wd_hold", rf_wd, 32'hDEADBEEF);

        // Four contested cycles: grants alternate req0, req1, req0, req1
        a_wa[0] = 5'd10; a_wd[0] = 32'hA0A0_0000;
        a_wa[1] = 5'd12; a_wd[1] = 32'hA1A1_1111;
        a_wa[2] = 5'd14; a_wd[2] = 32'hA2A2_2222;
        b_wa[0] = 5'd11; b_wd[0] = 32'hB0B0_0000;
        b_wa[1] = 5'd13; b_wd[1] = 32'hB1B1_1111;
        i0 = 0;
        i1 = 0;
        for (int c = 0; c < 4; c++) begin
            req0_valid = 1'b1; req0_wa = a_wa[i0]; req0_wd = a_wd[i0];
            req1_valid = 1'b1; req1_wa = b_wa[i1]; req1_wd = b_wd[i1];
            #1;
            check($sformatf("rr%0d_ready0", c), 32'(req0_ready), (c % 2 == 0) ? 1 : 0);
            check($sformatf("rr%0d_ready1", c), 32'(req1_ready), (c % 2 == 1) ? 1 : 0);
            tick();
            if (c % 2 == 0) begin
                check($sformatf("rr%0d_wa", c), 32'(rf_wa), 32'(a_wa[i0]));
                check($sformatf("rr%0d_wd", c), rf_wd, a_wd[i0]);
                i0++;
            end else begin
                check($sformatf("rr%0d_wa", c), 32'(rf_wa), 32'(b_wa[i1]));
                check($sformatf("rr%0d_wd", c), rf_wd, b_wd[i1]);
                i1++;
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;

        // Write to r0 is accepted and dropped
        req0_valid = 1'b1; req0_wa = 5'd0; req0_wd = 32'h1234;
        #1;
        check("r0_ready0", 32'(req0_ready), 1);
        tick();
        req0_valid = 1'b0;
        check("r0_regwrite", 32'(rf_regwrite), 0);
        check("r0_busy", busy_vec, 0);

        // Reserve r7, WAW from pipeline keeps it busy, multicycle write clears it
        rsv_valid = 1'b1; rsv_wa = 5'd7;
        tick();
        rsv_valid = 1'b0;
        chk_ra1 = 5'd7; chk_ra2 = 5'd0;
        #1;
        check("rsv7_vec", busy_vec, 32'h0000_0080);
        check("rsv7_chk1", 32'(chk_busy1), 1);
        check("rsv7_chk2_r0", 32'(chk_busy2), 0);
        req0_valid = 1'b1; req0_wa = 5'd7; req0_wd = 32'h77;
        tick();
        req0_valid = 1'b0;
        check("waw7_regwrite", 32'(rf_regwrite), 1);
        tick();
        check("waw7_busy", 32'(chk_busy1), 1);
        req1_valid = 1'b1; req1_wa = 5'd7; req1_wd = 32'h777;
        #1;
        check("mc7_ready1", 32'(req1_ready), 1);
        tick();
        req1_valid = 1'b0;
        check("mc7_regwrite", 32'(rf_regwrite), 1);
        check("mc7_wd", rf_wd, 32'h777);
        check("mc7_busy_before", 32'(chk_busy1), 1);
        tick();
        check("mc7_busy_after", 32'(chk_busy1), 0);
        check("mc7_vec", busy_vec, 0);

        // Double reservation of r9 raises a sticky error
        rsv_valid = 1'b1; rsv_wa = 5'd9;
        tick();
        check("rsv9_first_err", 32'(rsv_err), 0);
        tick();
        rsv_valid = 1'b0;
        check("rsv9_err", 32'(rsv_err), 1);
        check("rsv9_vec", busy_vec, 32'h0000_0200);
        tick();
        check("rsv9_err_sticky", 32'(rsv_err), 1);

        // Reservation on the same edge a multicycle write to r9 commits
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsv_valid = 1'b1; rsv_wa = 5'd9;
        tick();
        rsv_valid = 1'b0;
        req1_valid = 1'b1; req1_wa = 5'd9; req1_wd = 32'h9999;
        tick();
        req1_valid = 1'b0;
        check("same9_regwrite", 32'(rf_regwrite), 1);
        rsv_valid = 1'b1; rsv_wa = 5'd9;
        tick();
        rsv_valid = 1'b0;
        check("same9_busy", busy_vec, 32'h0000_0200);
        check("same9_err", 32'(rsv_err), 0);

        // Mid-operation reset with a contested cycle and reservation pending
        rsv_valid = 1'b1; rsv_wa = 5'd3;
        tick();
        req0_valid = 1'b1; req0_wa = 5'd20; req0_wd = 32'h2020;
        req1_valid = 1'b1; req1_wa = 5'd21; req1_wd = 32'h2121;
        tick();
        check("pre_rst_err", 32'(rsv_err), 1);
        check("pre_rst_ready1", 32'(req1_ready), 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        rsv_valid = 1'b0;
        check("mid_rst_regwrite", 32'(rf_regwrite), 0);
        check("mid_rst_busy", busy_vec, 0);
        check("mid_rst_err", 32'(rsv_err), 0);
        check("mid_rst_wd", rf_wd, 0);
        check("post_rst_ready0", 32'(req0_ready), 1);
        check("post_rst_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("post_rst_wa", 32'(rf_wa), 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
